// File: rtl/mul_datapath.sv
// Shift-add multiplier datapath.
// Holds the multiplicand, the {carry,hi,lo} product register and the
// WIDTH+1 bit adder, and executes the write/add/shift commands issued by the
// multiplier Control FSM. The product LSB is fed back to Control. A registered
// result with a one-cycle valid pulse is presented when Control raises ready.
//
// Command interface: there is no valid/ready handshake on the commands.
// run, w_ctrl, srl_ctrl and addu_ctrl are acted on at every rising edge they
// are presented, with run taking priority over everything else. "ready" is a
// level from Control; only its rising edge (run low) captures a result, and
// product_valid marks the single cycle in which that new result first appears.
module mul_datapath #(
  parameter int         WIDTH      = 32,
  parameter logic [5:0] ADDU_FUNCT = 6'h21
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [WIDTH-1:0]     multiplicand_in,
  input  logic [WIDTH-1:0]     multiplier_in,
  input  logic                 w_ctrl,
  input  logic [5:0]           addu_ctrl,
  input  logic                 srl_ctrl,
  input  logic                 ready,
  output logic                 lsb,
  output logic [2*WIDTH-1:0]   product,
  output logic                 product_valid,
  output logic                 shift_err
);

  // shcnt must be able to hold WIDTH+1, its saturation value.
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] SH_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] SH_MAX  = CW'(WIDTH + 1);

  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH:0]   preg_q, preg_d;      // {carry, hi, lo}
  logic [CW-1:0]      shcnt_q, shcnt_d;
  logic               ready_d_q;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;

  logic [WIDTH-1:0]   hi, lo, addend;
  logic [WIDTH:0]     sum;
  logic               do_shift;
  logic               capture;

  assign hi = preg_q[2*WIDTH-1:WIDTH];
  assign lo = preg_q[WIDTH-1:0];

  // Adder: hi plus either the multiplicand or zero. The old carry is not an
  // input; the fresh carry out lands in preg's top bit.
  always_comb begin
    addend = (addu_ctrl == ADDU_FUNCT) ? mcand_q : '0;
    sum    = {1'b0, hi} + {1'b0, addend};
  end

  // Next-state for operand, product register, shift counter and error flag.
  always_comb begin
    mcand_d  = mcand_q;
    preg_d   = preg_q;
    shcnt_d  = shcnt_q;
    err_d    = err_q;
    do_shift = 1'b0;
    if (run) begin
      // A load discards any in-flight work; commands this cycle are ignored.
      mcand_d = multiplicand_in;
      preg_d  = {1'b0, {WIDTH{1'b0}}, multiplier_in};
      shcnt_d = '0;
      err_d   = 1'b0;
    end else begin
      unique case ({w_ctrl, srl_ctrl})
        2'b10: preg_d = {sum, lo};
        2'b01: begin
          preg_d   = preg_q >> 1;
          do_shift = 1'b1;
        end
        2'b11: begin
          // Fused add-then-shift: {sum,lo} >> 1.
          preg_d   = {1'b0, sum, lo[WIDTH-1:1]};
          do_shift = 1'b1;
        end
        default: preg_d = preg_q;
      endcase
      if (do_shift) begin
        // One shift beyond WIDTH means Control lost track of the iteration.
        if (shcnt_q == SH_LAST) err_d = 1'b1;
        if (shcnt_q != SH_MAX) shcnt_d = shcnt_q + CW'(1);
      end
    end
  end

  // Result capture on the rising edge of ready, unless a load is happening.
  always_comb begin
    capture   = ready & ~ready_d_q & ~run;
    product_d = capture ? preg_q[2*WIDTH-1:0] : product_q;
    valid_d   = capture;
  end

  // State registers, all cleared by the shared asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q   <= '0;
      preg_q    <= '0;
      shcnt_q   <= '0;
      ready_d_q <= 1'b0;
      product_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      preg_q    <= preg_d;
      shcnt_q   <= shcnt_d;
      ready_d_q <= ready;
      product_q <= product_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign lsb           = preg_q[0];
  assign product       = product_q;
  assign product_valid = valid_q;
  assign shift_err     = err_q;

endmodule
